// File: rtl/addsub_pkg.sv
// Shared types and helpers for the byte-serial add/sub controller.
package addsub_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned MAX_BYTES = 32;
  localparam int unsigned MAX_W     = BYTE_W * MAX_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Callers zero-extend their vector to MAX_W; idx must stay below MAX_BYTES.
  function automatic logic [BYTE_W-1:0] byte_of(input logic [MAX_W-1:0] vec,
                                                input int unsigned      idx);
    return vec[idx*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/addsub_byte_sel.sv
// Combinational byte mux: selects byte idx of both latched operands.
module addsub_byte_sel
  import addsub_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic [BYTE_W*NBYTES-1:0]   opa,
  input  logic [BYTE_W*NBYTES-1:0]   opb,
  input  logic [$clog2(NBYTES)-1:0]  idx,
  output logic [BYTE_W-1:0]          a_byte,
  output logic [BYTE_W-1:0]          b_byte
);

  localparam int unsigned W = BYTE_W * NBYTES;

  logic [MAX_W-1:0] a_ext;
  logic [MAX_W-1:0] b_ext;

  always_comb begin
    a_ext        = '0;
    b_ext        = '0;
    a_ext[W-1:0] = opa;
    b_ext[W-1:0] = opb;
    a_byte       = byte_of(a_ext, 32'(idx));
    b_byte       = byte_of(b_ext, 32'(idx));
  end

endmodule

// File: rtl/addsub_seq.sv
// Byte-serial NBYTES-wide add/subtract sequencer driving an external 8-bit datapath.
// Optional signed-overflow output enabled by defining ADDSUB_SEQ_OVF_EN.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sub,
  input  logic [BYTE_W*NBYTES-1:0] opa,
  input  logic [BYTE_W*NBYTES-1:0] opb,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                     carry,
`ifdef ADDSUB_SEQ_OVF_EN
  output logic                     ovf,
`endif
  output logic [BYTE_W-1:0]        dp_add1,
  output logic [BYTE_W-1:0]        dp_add2,
  output logic                     dp_ci,
  output logic                     dp_flag,
  output logic                     dp_flip,
  input  logic [BYTE_W-1:0]        dp_sum,
  input  logic                     dp_co
);

  localparam int unsigned W  = BYTE_W * NBYTES;
  localparam int unsigned IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic            chain_q, chain_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef ADDSUB_SEQ_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;

  addsub_byte_sel #(.NBYTES(NBYTES)) u_byte_sel (
    .opa    (a_q),
    .opb    (b_q),
    .idx    (idx_q),
    .a_byte (a_byte),
    .b_byte (b_byte)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    chain_d  = chain_q;
    result_d = result_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = opa;
          b_d      = opb;
          sub_d    = sub;
          idx_d    = '0;
          chain_d  = 1'b0;
          result_d = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) result_d[i*BYTE_W +: BYTE_W] = dp_sum;
        end
        chain_d = dp_co;
        if (idx_q == LAST) begin
          carry_d = dp_co;
`ifdef ADDSUB_SEQ_OVF_EN
          // Subtract overflows when operand signs differ; add when they match.
          ovf_d   = ((a_q[W-1] ^ b_q[W-1]) == sub_q) && (dp_sum[BYTE_W-1] != a_q[W-1]);
`endif
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      chain_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      chain_q  <= chain_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Datapath is only claimed while RUN; it idles at zero for other users.
  always_comb begin
    dp_add1 = '0;
    dp_add2 = '0;
    dp_ci   = 1'b0;
    dp_flag = 1'b0;
    dp_flip = 1'b0;
    if (state_q == RUN) begin
      dp_add1 = a_byte;
      dp_add2 = b_byte;
      dp_ci   = chain_q;
      dp_flag = (idx_q != '0);
      dp_flip = sub_q;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
`ifdef ADDSUB_SEQ_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// Directed self-checking bench for addsub_seq (NBYTES=4) with a behavioural 8-bit datapath.
module tb_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry;
`ifdef ADDSUB_SEQ_OVF_EN
  logic        ovf;
`endif
  logic [7:0]  dp_add1;
  logic [7:0]  dp_add2;
  logic        dp_ci;
  logic        dp_flag;
  logic        dp_flip;
  logic [7:0]  dp_sum;
  logic        dp_co;
  logic [8:0]  dp_tmp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addsub_seq #(.NBYTES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sub     (sub),
    .opa     (opa),
    .opb     (opb),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry),
`ifdef ADDSUB_SEQ_OVF_EN
    .ovf     (ovf),
`endif
    .dp_add1 (dp_add1),
    .dp_add2 (dp_add2),
    .dp_ci   (dp_ci),
    .dp_flag (dp_flag),
    .dp_flip (dp_flip),
    .dp_sum  (dp_sum),
    .dp_co   (dp_co)
  );

  always_comb begin
    dp_tmp = {1'b0, dp_add1} + {1'b0, (dp_add2 ^ {8{dp_flip}})}
           + {8'b0, (dp_flip ^ (dp_flag & dp_ci))};
    dp_sum = dp_tmp[7:0];
    dp_co  = dp_flip ^ dp_tmp[8];
  end

  // Launches one operation, scrambles the inputs afterwards, and observes 8 cycles.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int done_cyc, output int busy_cyc, output int dones,
                       output logic [3:0] flags);
    @(negedge clk);
    opa = a; opb = b; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; opa = ~a; opb = ~b; sub = ~s;
    done_cyc = -1; busy_cyc = 0; dones = 0; flags = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (i <= 4) flags[i-1] = dp_flag;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", result); end
    n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b exp 0", carry); end
    n_checks++;
    if ({dp_add1, dp_add2, dp_ci, dp_flag, dp_flip} !== 19'h0) begin
      n_fail++; $display("FAIL reset_dp_idle got %h exp 0", {dp_add1, dp_add2, dp_ci, dp_flag, dp_flip});
    end
  endtask

  task automatic test_add_ripple();
    int dc, bc, dn; logic [3:0] fl;
    do_op(32'h000000FF, 32'h00000001, 1'b0, dc, bc, dn, fl);
    n_checks++; if (result !== 32'h00000100) begin n_fail++; $display("FAIL add_ripple_result got %h exp 00000100", result); end
    n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL add_ripple_carry got %b exp 0", carry); end
    n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL add_latency got %0d exp 5", dc); end
    n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL add_busy_cycles got %0d exp 5", bc); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL add_done_pulses got %0d exp 1", dn); end
  endtask

  task automatic test_add_wrap();
    int dc, bc, dn; logic [3:0] fl;
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, dc, bc, dn, fl);
    n_checks++; if (result !== 32'h00000000) begin n_fail++; $display("FAIL add_wrap_result got %h exp 00000000", result); end
    n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL add_wrap_carry got %b exp 1", carry); end
    n_checks++; if (fl !== 4'b1110) begin n_fail++; $display("FAIL add_wrap_flags got %b exp 1110", fl); end
  endtask

  task automatic test_sub();
    int dc, bc, dn; logic [3:0] fl;
    do_op(32'h00000100, 32'h00000001, 1'b1, dc, bc, dn, fl);
    n_checks++; if (result !== 32'h000000FF) begin n_fail++; $display("FAIL sub_result got %h exp 000000FF", result); end
    n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL sub_borrow got %b exp 0", carry); end
    n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL sub_latency got %0d exp 5", dc); end
    do_op(32'h00000000, 32'h00000001, 1'b1, dc, bc, dn, fl);
    n_checks++; if (result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sub_under_result got %h exp FFFFFFFF", result); end
    n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL sub_under_borrow got %b exp 1", carry); end
  endtask

  task automatic test_start_ignored();
    int dn = 0; int dc = -1;
    @(negedge clk);
    opa = 32'h11111111; opb = 32'h22222222; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 2) begin start = 1'b1; opa = 32'h12345678; end
      if (i == 3) start = 1'b0;
      if (done) begin dn++; if (dc < 0) dc = i; end
    end
    n_checks++; if (result !== 32'h33333333) begin n_fail++; $display("FAIL busy_start_result got %h exp 33333333", result); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL busy_start_dones got %0d exp 1", dn); end
    n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL busy_start_latency got %0d exp 5", dc); end
  endtask

  task automatic test_mid_reset();
    int dc, bc, dn; logic [3:0] fl;
    @(negedge clk);
    opa = 32'hFFFFFFFF; opb = 32'hFFFFFFFF; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b exp 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL midrst_result got %h exp 0", result); end
    n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL midrst_carry got %b exp 0", carry); end
    do_op(32'h01020304, 32'h10203040, 1'b0, dc, bc, dn, fl);
    n_checks++; if (result !== 32'h11223344) begin n_fail++; $display("FAIL midrst_fresh_result got %h exp 11223344", result); end
    n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL midrst_fresh_latency got %0d exp 5", dc); end
  endtask

`ifdef ADDSUB_SEQ_OVF_EN
  task automatic test_ovf();
    int dc, bc, dn; logic [3:0] fl;
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, dc, bc, dn, fl);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_add got %b exp 1", ovf); end
    n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL ovf_add_carry got %b exp 0", carry); end
    do_op(32'h80000000, 32'h00000001, 1'b1, dc, bc, dn, fl);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sub got %b exp 1", ovf); end
    n_checks++; if (result !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL ovf_sub_result got %h exp 7FFFFFFF", result); end
    do_op(32'h00000005, 32'h00000003, 1'b1, dc, bc, dn, fl);
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_none got %b exp 0", ovf); end
    n_checks++; if (result !== 32'h00000002) begin n_fail++; $display("FAIL ovf_none_result got %h exp 00000002", result); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_ripple();
    test_add_wrap();
    test_sub();
    test_start_ignored();
    test_mid_reset();
`ifdef ADDSUB_SEQ_OVF_EN
    test_ovf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
